// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle main control FSM
// Sequences fetch/decode/execute/memory/writeback and drives ALU selects and datapath enables.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic       retire
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXECR     = 4'd6;
  localparam logic [3:0] S_EXECI     = 4'd7;
  localparam logic [3:0] S_LUI       = 4'd8;
  localparam logic [3:0] S_AUIPC     = 4'd9;
  localparam logic [3:0] S_ALUWB     = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_JALR      = 4'd13;
  localparam logic [3:0] S_JALR_LINK = 4'd14;
  localparam logic [3:0] S_ILLEGAL   = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       branch_taken;
  logic       branch_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_ILLEGAL) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    branch_bad   = 1'b0;
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = !ltu;
      default: branch_bad   = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      // op[5] separates store (0100011) from load (0000011)
      S_MEMADR:    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:     state_next = S_FETCH;
      S_MEMWRITE:  if (mem_ready) state_next = S_FETCH;
      S_EXECR:     state_next = S_ALUWB;
      S_EXECI:     state_next = S_ALUWB;
      S_LUI:       state_next = S_ALUWB;
      S_AUIPC:     state_next = S_ALUWB;
      S_ALUWB:     state_next = S_FETCH;
      S_BRANCH:    state_next = branch_bad ? S_ILLEGAL : S_FETCH;
      S_JAL:       state_next = S_ALUWB;
      S_JALR:      state_next = S_JALR_LINK;
      S_JALR_LINK: state_next = S_FETCH;
      S_ILLEGAL:   state_next = S_ILLEGAL;
      default:     state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // state is forced to FETCH while in reset; keep the enables quiet then
        if (mem_ready && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b01;
        pc_write  = branch_taken && !branch_bad;
        retire    = !branch_bad;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_JALR, OP_I: imm_src = 3'b000;
      OP_STORE:               imm_src = 3'b001;
      OP_BRANCH:              imm_src = 3'b010;
      OP_JAL:                 imm_src = 3'b011;
      OP_LUI, OP_AUIPC:       imm_src = 3'b100;
      default:                imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
// Directed table, hand-written corner sequences and randomized instructions against a per-phase model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic       illegal, retire;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal), .retire(retire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       illegal, retire;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, l, lu;
    int         fw, mw;
    int         exp_cycles;
  } vec_t;

  int    checks = 0;
  int    fails  = 0;
  outs_t exp_q[$];
  logic  rdy_q[$];
  logic [2:0] cur_imm;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b1100111, 7'b0010011: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t o(input logic rq, we, as, irw, pcw, rw,
                              input logic [1:0] rs, sa, sb, aop,
                              input logic ill, ret);
    outs_t v;
    v = {rq, we, as, irw, pcw, rw, rs, sa, sb, aop, cur_imm, ill, ret};
    return v;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int base_cycles(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b1100011: return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic outs_t dut_outs();
    outs_t v;
    v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
         result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, retire};
    return v;
  endfunction

  task automatic push(input outs_t v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  task automatic push_illegal();
    for (int i = 0; i < 12; i++) push(o(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0), rnd());
  endtask

  // Expected cycle-by-cycle outputs for one instruction, phase by phase.
  task automatic build(input logic [6:0] op_i, input logic [2:0] f3, input logic z, l, lu,
                       input int fw, mw);
    logic taken;
    exp_q.delete();
    rdy_q.delete();
    cur_imm = imm_of(op_i);
    for (int i = 0; i < fw; i++) push(o(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0), 1'b0);
    push(o(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0,0), 1'b1);
    push(o(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0), rnd());
    case (op_i)
      7'b0000011: begin
        push(o(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0), rnd());
        for (int i = 0; i < mw; i++) push(o(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0), 1'b0);
        push(o(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0), 1'b1);
        push(o(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0,1), rnd());
      end
      7'b0100011: begin
        push(o(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0), rnd());
        for (int i = 0; i < mw; i++) push(o(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0), 1'b0);
        push(o(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1), 1'b1);
      end
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111: begin
        case (op_i)
          7'b0110011: push(o(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0), rnd());
          7'b0010011: push(o(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0), rnd());
          7'b0110111: push(o(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0,0), rnd());
          7'b0010111: push(o(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0), rnd());
          default:    push(o(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,0,0), rnd());
        endcase
        push(o(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,1), rnd());
      end
      7'b1100111: begin
        push(o(0,0,0,0,1,0,2'b10,2'b10,2'b01,2'b00,0,0), rnd());
        push(o(0,0,0,0,0,1,2'b10,2'b01,2'b10,2'b00,0,1), rnd());
      end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          push(o(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0,0), rnd());
          push_illegal();
        end else begin
          case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = l;
            3'b101:  taken = !l;
            3'b110:  taken = lu;
            default: taken = !lu;
          endcase
          push(o(0,0,0,0,taken,0,2'b00,2'b10,2'b00,2'b01,0,1), rnd());
        end
      end
      default: push_illegal();
    endcase
  endtask

  task automatic chk(input string name, input int idx, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %05h expected %05h", name, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic run_seq(input string name, input int limit, output int ret_cnt, output int ret_at);
    ret_cnt = 0;
    ret_at  = -1;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      mem_ready = rdy_q[i];
      #1;
      chk(name, i, dut_outs(), exp_q[i]);
      if (retire === 1'b1) begin
        ret_cnt++;
        if (ret_at < 0) ret_at = i + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_in(input logic [6:0] op_i, input logic [2:0] f3, input logic z, l, lu);
    op = op_i; funct3 = f3; zero = z; lt = l; ltu = lu;
  endtask

  // Hold reset for two edges with mem_ready=1, release on a falling edge.
  task automatic do_reset(input string name);
    cur_imm   = imm_of(op);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk(name, 0, dut_outs(), o(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0));
    @(negedge clk);
    #1;
    chk(name, 1, dut_outs(), o(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input string name, input logic [6:0] op_i, input logic [2:0] f3,
                           input logic z, l, lu, input int fw, mw, exp_cycles, exp_ret);
    int rc, ra;
    set_in(op_i, f3, z, l, lu);
    build(op_i, f3, z, l, lu, fw, mw);
    run_seq(name, 1000, rc, ra);
    chk_int({name, " retire count"}, rc, exp_ret);
    if (exp_ret > 0) chk_int({name, " cycles"}, ra, exp_cycles);
  endtask

  vec_t tbl[13];
  logic [6:0] legal_ops[9];
  logic [2:0] br_f3[6];

  initial begin
    tbl[0]  = '{7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4};
    tbl[1]  = '{7'b0010011, 3'b000, 0, 0, 0, 0, 0, 4};
    tbl[2]  = '{7'b0000011, 3'b010, 0, 0, 0, 0, 3, 8};
    tbl[3]  = '{7'b0100011, 3'b010, 0, 0, 0, 0, 0, 4};
    tbl[4]  = '{7'b1100011, 3'b000, 1, 0, 0, 0, 0, 3};
    tbl[5]  = '{7'b1100011, 3'b001, 1, 0, 0, 0, 0, 3};
    tbl[6]  = '{7'b1100011, 3'b110, 0, 0, 1, 0, 0, 3};
    tbl[7]  = '{7'b1101111, 3'b000, 0, 0, 0, 0, 0, 4};
    tbl[8]  = '{7'b1100111, 3'b000, 0, 0, 0, 0, 0, 4};
    tbl[9]  = '{7'b0110111, 3'b000, 0, 0, 0, 0, 0, 4};
    tbl[10] = '{7'b0010111, 3'b000, 0, 0, 0, 2, 0, 6};
    tbl[11] = '{7'b0100011, 3'b000, 0, 0, 0, 0, 2, 6};
    tbl[12] = '{7'b1100011, 3'b101, 0, 0, 0, 1, 0, 4};
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    rst_n = 1'b0;
    set_in(7'b0110011, 3'b000, 0, 0, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 13; i++) begin
      run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].l, tbl[i].lu,
                tbl[i].fw, tbl[i].mw, tbl[i].exp_cycles, 1);
    end

    for (int n = 0; n < 200; n++) begin
      logic [6:0] rop;
      logic [2:0] rf3;
      int fw, mw, cyc;
      rop = legal_ops[$urandom_range(0, 8)];
      rf3 = (rop == 7'b1100011) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      cyc = base_cycles(rop) + fw;
      if (rop == 7'b0000011 || rop == 7'b0100011) cyc = cyc + mw;
      run_instr($sformatf("rnd%0d", n), rop, rf3, rnd(), rnd(), rnd(), fw, mw, cyc, 1);
    end

    begin : mid_reset
      int rc, ra;
      set_in(7'b0000011, 3'b010, 0, 0, 0);
      build(7'b0000011, 3'b010, 0, 0, 0, 0, 0);
      run_seq("lw_abort", 3, rc, ra);
      do_reset("mid_reset");
      run_instr("add_after_abort", 7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4, 1);
    end

    run_instr("fence_illegal", 7'b0001111, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    do_reset("illegal_reset");
    run_instr("add_after_illegal", 7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4, 1);

    run_instr("branch_f3_010", 7'b1100011, 3'b010, 1, 1, 1, 1, 0, 0, 0);
    do_reset("branch_illegal_reset");
    run_instr("lw_after_illegal", 7'b0000011, 3'b010, 0, 0, 0, 0, 1, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the RV32I multicycle core. Sequences fetch, decode, execute, memory and writeback over several cycles. Drives the shared ALU through ALUOp/ALUSrcA/ALUSrcB; ALU_decoder turns ALUOp into ALUControl. Also generates the datapath enables and waits on a single-port memory through a req/ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- zero, lt, ltu  in  1 each  ALU flags: result==0, signed A<B, unsigned A<B
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access in progress
- mem_write  out  1  store
- adr_src  out  1  0=PC, 1=Result
- ir_write  out  1  latch instruction and OldPC
- pc_write  out  1  load PC from Result
- reg_write  out  1  register file write
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg A, 11=zero
- alu_src_b  out  2  00=rs2 reg, 01=ImmExt, 10=constant 4
- alu_op  out  2  00=add, 01=sub/compare, 10=funct-decoded
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U (decoded from op)
- illegal  out  1  sticky illegal-opcode flag
- retire  out  1  one-cycle pulse on the last cycle of each instruction

## Operation
- Outputs are Moore-decoded from state, except pc_write, ir_write, retire and BRANCH pc_write, which also depend on inputs. Unlisted outputs are 0; alu_op=00 and result_src=00 unless stated.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold.
- DECODE:
  - alu_src_a=01, alu_src_b=01, so ALUOut=OldPC+imm.
  - Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready: retire=1, go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, then ALUWB.
- AUIPC: alu_src_a=01, alu_src_b=01, then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, then FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, retire=1, then FETCH.
  - pc_write = taken, by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 -> ILLEGAL, pc_write=0, retire=0.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1, then ALUWB (rd=OldPC+4).
- JALR: alu_src_a=10, alu_src_b=01, result_src=10, pc_write=1, then JALR_LINK.
- JALR_LINK: alu_src_a=01, alu_src_b=10, result_src=10, reg_write=1, retire=1, then FETCH.
- ILLEGAL:
  - illegal=1; all write enables and mem_req are 0.
  - Stays in ILLEGAL until rst_n=0.
- imm_src is combinational from op:
  - load/JALR/I-ALU 000, store 001, branch 010, JAL 011, LUI/AUIPC 100, else 000.

## Timing
- Reset (async, rst_n=0): state=FETCH and illegal=0.
  - Outputs take FETCH values: mem_req=1, alu_src_b=10, result_src=10.
  - ir_write/pc_write stay 0 while rst_n=0, even if mem_ready=1.
- A release of rst_n mid-instruction restarts at FETCH. No partial writes are issued after release.
- mem_req stays high, with adr_src and mem_write stable, until mem_ready is sampled 1. ready with req=0 is ignored.
- Cycle counts with mem_ready tied 1:
  - R/I-ALU/LUI/AUIPC/JAL/JALR/store: 4 cycles
  - load: 5 cycles
  - branch: 3 cycles
- Each wait cycle adds 1.
- retire is high for exactly one cycle per completed instruction and never in ILLEGAL.

## Test plan
- Reset with mem_ready=1 held: rst_n low → FETCH outputs, ir_write=0. Release → ir_write=1 in the first cycle.
- add (op 0110011), mem_ready=1: states FETCH, DECODE, EXECR, ALUWB.
  - alu_op=10 in EXECR; reg_write=1 and retire=1 in cycle 4 only.
- lw with mem_ready low for 3 cycles in MEMREAD: mem_req and adr_src=1 hold for 4 cycles, then MEMWB reg_write with result_src=01. Total 8 cycles.
- Branches:
  - beq with zero=1 → pc_write=1 in BRANCH.
  - bne with zero=1 → pc_write=0.
  - bltu with ltu=1 → pc_write=1.
  - All three: retire=1, 3 cycles.
- jalr: pc_write=1 with result_src=10 in JALR, then reg_write=1 with alu_src_a=01, alu_src_b=10 in JALR_LINK.
- Illegal cases:
  - op 0001111 → illegal=1, no writes for 10+ cycles; reset clears it.
  - branch funct3=010 → also ILLEGAL.
